// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath and mem_responder, plus the preload strobe.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [12:0]       addr;
    logic [12:0]       wdata;
    logic              read;
    logic              write;
    logic              instruction;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [12:0]       load_data;
    logic [12:0]       dataOut;
    logic              memDone;
    logic              err;

    modport master (
        output addr, wdata, read, write, instruction, load_en, load_addr, load_data,
        input  dataOut, memDone, err
    );

    modport slave (
        input  addr, wdata, read, write, instruction, load_en, load_addr, load_data,
        output dataOut, memDone, err
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one request in flight, registered completion pulse and read data.
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int unsigned Words   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [12:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ins_q, ins_d;
    logic [12:0]       dout_q, dout_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [12:0]       mem_wdata;
    logic [12:0]       mem_q [Words];

    logic [ADDR_W-1:0] req_idx;
    logic              unused_addr;

    // Region bit comes from the instruction flag; high address bits simply wrap.
    assign req_idx     = {~bus.instruction, bus.addr[ADDR_W-2:0]};
    assign unused_addr = ^bus.addr[12:ADDR_W-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        ins_d     = ins_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.read || bus.write) begin
                    idx_d   = req_idx;
                    wdata_d = bus.wdata;
                    rd_d    = bus.read;
                    wr_d    = bus.write;
                    ins_d   = bus.instruction;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end else if (bus.load_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.load_addr;
                    mem_wdata = bus.load_data;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRelease;
                    done_d  = 1'b1;
                    if (rd_q && wr_q) begin
                        err_d = 1'b1;
                    end else if (rd_q) begin
                        dout_d = mem_q[idx_q];
                    end else if (ins_q) begin
                        // Instruction region is read-only.
                        err_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = idx_q;
                        mem_wdata = wdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRelease: begin
                if (!bus.read && !bus.write) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ins_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ins_q   <= ins_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset, but reset still blocks any write landing in that cycle.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.dataOut = dout_q;
    assign bus.memDone = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: runs the same request sequence against LATENCY 1, 2 and 4 instances.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] addr = '0;
    logic [12:0] wdata = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        instruction = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [12:0] load_data = '0;

    int sel = 0;
    int cur_lat = 1;
    int n_checks = 0;
    int n_fail = 0;

    logic [12:0] dout_a [3];
    logic        done_a [3];
    logic        err_a  [3];
    logic [12:0] obs_dout;
    logic        obs_done;
    logic        obs_err;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned Lat = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        logic on;
        mem_responder_if #(.ADDR_W(8)) bus ();

        // Only the selected instance sees stimulus; the others stay idle.
        assign on              = (sel == gi);
        assign bus.addr        = on ? addr : '0;
        assign bus.wdata       = on ? wdata : '0;
        assign bus.read        = on ? read : 1'b0;
        assign bus.write       = on ? write : 1'b0;
        assign bus.instruction = on ? instruction : 1'b0;
        assign bus.load_en     = on ? load_en : 1'b0;
        assign bus.load_addr   = load_addr;
        assign bus.load_data   = load_data;

        mem_responder #(.ADDR_W(8), .LATENCY(Lat)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign dout_a[gi] = bus.dataOut;
        assign done_a[gi] = bus.memDone;
        assign err_a[gi]  = bus.err;
    end

    always_comb begin
        obs_dout = dout_a[sel];
        obs_done = done_a[sel];
        obs_err  = err_a[sel];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (LATENCY=%0d): got %0h, expected %0h", tag, cur_lat, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] ia, input logic [12:0] d);
        load_en   = 1'b1;
        load_addr = ia;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issues a request, checks completion lands exactly LATENCY edges after acceptance.
    task automatic request(input string tag, input logic rd, input logic wr, input logic ins,
                           input logic [12:0] a, input logic [12:0] wd, input logic exp_err,
                           input logic [12:0] exp_dout, input int hold);
        int k;
        read        = rd;
        write       = wr;
        instruction = ins;
        addr        = a;
        wdata       = wd;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (obs_done) break;
        end
        check_eq({tag, "_latency"}, k, cur_lat + 1);
        check_eq({tag, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
        check_eq({tag, "_dout"}, {19'd0, obs_dout}, {19'd0, exp_dout});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_held_no_done"}, {31'd0, obs_done}, 32'd0);
        end
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_one(input int which, input int lat);
        sel     = which;
        cur_lat = lat;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_dout", {19'd0, obs_dout}, 32'd0);
        check_eq("reset_done", {31'd0, obs_done}, 32'd0);
        check_eq("reset_err", {31'd0, obs_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        load(8'd5, 13'h00A3);
        load(8'd7, 13'h0111);
        load(8'd3, 13'h0333);
        load(8'd137, 13'h0000);
        check_eq("load_no_done", {31'd0, obs_done}, 32'd0);

        request("t1_read_held", 1'b1, 1'b0, 1'b1, 13'd5, 13'h0, 1'b0, 13'h00A3, 3);

        request("t2_write", 1'b0, 1'b1, 1'b0, 13'd3, 13'h1FFF, 1'b0, 13'h00A3, 0);
        request("t2_readback", 1'b1, 1'b0, 1'b0, 13'd3, 13'h0, 1'b0, 13'h1FFF, 0);
        request("t2_instr_intact", 1'b1, 1'b0, 1'b1, 13'd3, 13'h0, 1'b0, 13'h0333, 0);

        request("t3_instr_write", 1'b0, 1'b1, 1'b1, 13'd7, 13'h1234, 1'b1, 13'h0333, 0);
        request("t3_readback", 1'b1, 1'b0, 1'b1, 13'd7, 13'h0, 1'b0, 13'h0111, 0);

        request("t4_rd_wr", 1'b1, 1'b1, 1'b0, 13'd3, 13'h0AAA, 1'b1, 13'h0111, 0);
        request("t4_readback", 1'b1, 1'b0, 1'b0, 13'd3, 13'h0, 1'b0, 13'h1FFF, 0);

        // Reset while the write is in flight must drop it.
        write       = 1'b1;
        instruction = 1'b0;
        addr        = 13'd9;
        wdata       = 13'h0555;
        @(negedge clk);
        check_eq("t5_busy_no_done", {31'd0, obs_done}, 32'd0);
        reset = 1'b1;
        write = 1'b0;
        @(negedge clk);
        check_eq("t5_reset_done", {31'd0, obs_done}, 32'd0);
        check_eq("t5_reset_dout", {19'd0, obs_dout}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t5_after_reset_no_done", {31'd0, obs_done}, 32'd0);
        end
        request("t5_readback", 1'b1, 1'b0, 1'b0, 13'd9, 13'h0, 1'b0, 13'h0000, 0);

        request("t6_alias_instr", 1'b1, 1'b0, 1'b1, 13'h1085, 13'h0, 1'b0, 13'h00A3, 0);
        request("t6_alias_data", 1'b1, 1'b0, 1'b0, 13'h1083, 13'h0, 1'b0, 13'h1FFF, 0);
    endtask

    initial begin
        run_one(0, 1);
        run_one(1, 2);
        run_one(2, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
